// File: rtl/sap_controller.sv
// SAP controller/sequencer: one-hot T1..T6 ring with a sticky halt.
// Every datapath strobe is decoded combinationally from (tstate, opcode).
module sap_controller #(
   parameter logic [3:0] OPC_LDA = 4'h0,
   parameter logic [3:0] OPC_ADD = 4'h1,
   parameter logic [3:0] OPC_SUB = 4'h2,
   parameter logic [3:0] OPC_OUT = 4'hE,
   parameter logic [3:0] OPC_HLT = 4'hF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [3:0] opcode,
   output logic [5:0] tstate,
   output logic       halted,
   output logic       pc_inc,
   output logic       pc_en,
   output logic       mar_load,
   output logic       ram_en,
   output logic       ir_load,
   output logic       ir_en,
   output logic       a_load,
   output logic       a_en,
   output logic       alu_sub,
   output logic       alu_en,
   output logic       b_load,
   output logic       out_load
);

   typedef enum logic [5:0] {
      T_HALT = 6'b000000,
      T1     = 6'b000001,
      T2     = 6'b000010,
      T3     = 6'b000100,
      T4     = 6'b001000,
      T5     = 6'b010000,
      T6     = 6'b100000
   } tstate_t;

   tstate_t state_reg, state_next;
   logic    halted_reg, halted_next;
   logic    active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= T1;
         halted_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         halted_reg <= halted_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      halted_next = halted_reg;
      if (run && !halted_reg) begin
         if (state_reg == T4 && opcode == OPC_HLT) begin
            state_next  = T_HALT;
            halted_next = 1'b1;
         end else begin
            case (state_reg)
               T1:      state_next = T2;
               T2:      state_next = T3;
               T3:      state_next = T4;
               T4:      state_next = T5;
               T5:      state_next = T6;
               T6:      state_next = T1;
               // an all-zero ring without the halt flag cannot occur; recover to fetch
               default: state_next = T1;
            endcase
         end
      end
   end

   // Strobes are forced low during reset, pause and halt.
   assign active = rst_n & run & ~halted_reg;

   always_comb begin
      pc_inc   = 1'b0;
      pc_en    = 1'b0;
      mar_load = 1'b0;
      ram_en   = 1'b0;
      ir_load  = 1'b0;
      ir_en    = 1'b0;
      a_load   = 1'b0;
      a_en     = 1'b0;
      alu_sub  = 1'b0;
      alu_en   = 1'b0;
      b_load   = 1'b0;
      out_load = 1'b0;
      if (active) begin
         case (state_reg)
            T1: begin
               pc_en    = 1'b1;
               mar_load = 1'b1;
            end
            T2: pc_inc = 1'b1;
            T3: begin
               ram_en  = 1'b1;
               ir_load = 1'b1;
            end
            T4: begin
               if (opcode == OPC_LDA || opcode == OPC_ADD || opcode == OPC_SUB) begin
                  ir_en    = 1'b1;
                  mar_load = 1'b1;
               end else if (opcode == OPC_OUT) begin
                  a_en     = 1'b1;
                  out_load = 1'b1;
               end
            end
            T5: begin
               if (opcode == OPC_LDA) begin
                  ram_en = 1'b1;
                  a_load = 1'b1;
               end else if (opcode == OPC_ADD || opcode == OPC_SUB) begin
                  ram_en = 1'b1;
                  b_load = 1'b1;
               end
            end
            T6: begin
               if (opcode == OPC_ADD || opcode == OPC_SUB) begin
                  alu_en  = 1'b1;
                  a_load  = 1'b1;
                  alu_sub = (opcode == OPC_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign tstate = state_reg;
   assign halted = halted_reg;

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: a reference sequencer model pushes the
// expected state/strobes each cycle, and the DUT outputs are popped against it.
module tb_sap_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic [3:0] opcode;
   logic [5:0] tstate;
   logic       halted;
   logic       pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
   logic       a_load, a_en, alu_sub, alu_en, b_load, out_load;

   sap_controller dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .opcode   (opcode),
      .tstate   (tstate),
      .halted   (halted),
      .pc_inc   (pc_inc),
      .pc_en    (pc_en),
      .mar_load (mar_load),
      .ram_en   (ram_en),
      .ir_load  (ir_load),
      .ir_en    (ir_en),
      .a_load   (a_load),
      .a_en     (a_en),
      .alu_sub  (alu_sub),
      .alu_en   (alu_en),
      .b_load   (b_load),
      .out_load (out_load)
   );

   always #5 clk = ~clk;

   // strobe vector bit positions
   localparam int S_PCINC = 11, S_PCEN = 10, S_MARL = 9, S_RAMEN = 8, S_IRL = 7, S_IREN = 6;
   localparam int S_AL = 5, S_AEN = 4, S_SUB = 3, S_ALUEN = 2, S_BL = 1, S_OUTL = 0;

   typedef struct packed {
      logic [5:0]  ts;
      logic        h;
      logic [11:0] st;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   m_t   = 0;      // model T-state index, 0 = T1
   logic m_halted = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] model_strobes(input int t, input logic [3:0] op, input logic act);
      logic [11:0] s;
      s = '0;
      if (act) begin
         case (t)
            0: begin s[S_PCEN] = 1'b1; s[S_MARL] = 1'b1; end
            1: s[S_PCINC] = 1'b1;
            2: begin s[S_RAMEN] = 1'b1; s[S_IRL] = 1'b1; end
            3: if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                  s[S_IREN] = 1'b1; s[S_MARL] = 1'b1;
               end else if (op == 4'hE) begin
                  s[S_AEN] = 1'b1; s[S_OUTL] = 1'b1;
               end
            4: if (op == 4'h0) begin
                  s[S_RAMEN] = 1'b1; s[S_AL] = 1'b1;
               end else if (op == 4'h1 || op == 4'h2) begin
                  s[S_RAMEN] = 1'b1; s[S_BL] = 1'b1;
               end
            5: if (op == 4'h1 || op == 4'h2) begin
                  s[S_ALUEN] = 1'b1; s[S_AL] = 1'b1; s[S_SUB] = (op == 4'h2);
               end
            default: ;
         endcase
      end
      return s;
   endfunction

   task automatic model_adv(input logic r, input logic [3:0] op);
      if (r && !m_halted) begin
         if (m_t == 3 && op == 4'hF) m_halted = 1'b1;
         else m_t = (m_t + 1) % 6;
      end
   endtask

   task automatic check_now(input string tag);
      exp_t e, g;
      e.h  = m_halted;
      e.ts = m_halted ? 6'd0 : (6'd1 << m_t);
      e.st = model_strobes(m_t, opcode, rst_n && run && !m_halted);
      sb_q.push_back(e);
      g = sb_q.pop_front();
      check_val({tag, ".tstate"}, 32'(tstate), 32'(g.ts));
      check_val({tag, ".halted"}, 32'(halted), 32'(g.h));
      check_val({tag, ".strobes"},
                32'({pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
                     a_load, a_en, alu_sub, alu_en, b_load, out_load}), 32'(g.st));
      check_val({tag, ".bus1hot"}, 32'($countones({pc_en, ram_en, ir_en, a_en, alu_en}) <= 1), 32'd1);
      check_val({tag, ".subgate"}, 32'(alu_sub & ~alu_en), 32'd0);
      $display("vec %0d %s run=%0b op=%h ts=%b h=%0b", n_vec, tag, run, opcode, tstate, halted);
   endtask

   // Called at a falling edge: drive, check, let the rising edge advance the model.
   task automatic cyc(input string tag, input logic r, input logic [3:0] op);
      run    = r;
      opcode = op;
      #1 check_now(tag);
      @(posedge clk);
      if (rst_n) model_adv(r, op);
      @(negedge clk);
   endtask

   task automatic fetch(input string tag);
      for (int i = 0; i < 3; i++) cyc(tag, 1'b1, 4'($urandom_range(0, 15)));
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      m_t = 0;
      m_halted = 1'b0;
      #1 check_now({tag, ".async"});
      @(negedge clk);
      check_now({tag, ".held"});
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      run    = 1'b1;
      opcode = 4'h0;
      repeat (2) @(negedge clk);
      #1 check_now("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // LDA: full ring and wrap to T1
      for (int i = 0; i < 7; i++) cyc("lda", 1'b1, 4'h0);
      for (int i = 0; i < 5; i++) cyc("lda2", 1'b1, 4'h0);

      // SUB with varying opcode during fetch
      fetch("sub_f");
      for (int i = 0; i < 3; i++) cyc("sub", 1'b1, 4'h2);

      // OUT then next T1
      fetch("out_f");
      for (int i = 0; i < 3; i++) cyc("out", 1'b1, 4'hE);
      cyc("out_t1", 1'b1, 4'h0);

      // pause in T2
      for (int i = 0; i < 3; i++) cyc("pause_t2", 1'b0, 4'h0);
      for (int i = 0; i < 5; i++) cyc("resume", 1'b1, 4'h0);

      // ADD with pause in T5
      fetch("add_f");
      cyc("add_t4", 1'b1, 4'h1);
      for (int i = 0; i < 2; i++) cyc("add_pause", 1'b0, 4'h1);
      for (int i = 0; i < 2; i++) cyc("add", 1'b1, 4'h1);

      // NOP opcode
      fetch("nop_f");
      for (int i = 0; i < 3; i++) cyc("nop", 1'b1, 4'h7);

      // ADD aborted by async reset mid-T5
      fetch("abort_f");
      cyc("abort_t4", 1'b1, 4'h1);
      run = 1'b1;
      opcode = 4'h1;
      #1 check_now("abort_t5");
      async_reset("abort");

      // HLT: freeze for 20 cycles, then reset pulse
      fetch("hlt_f");
      cyc("hlt_t4", 1'b1, 4'hF);
      for (int i = 0; i < 20; i++) cyc("halted", 1'b1, 4'($urandom_range(0, 15)));
      async_reset("hlt_rst");
      cyc("post_hlt", 1'b1, 4'h0);

      // randomized opcodes and run
      for (int i = 0; i < 300; i++)
         cyc("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 14)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
Controller/sequencer for the SAP datapath, the consumer of the Instruction Register's upper nibble. A one-hot 6-state ring counter (T1..T6) sequences each instruction. Fetch runs in T1..T3; execute runs in T4..T6 and is decoded from the 4-bit opcode. The block drives every datapath load/enable strobe and latches a sticky halt.

Parameters:
OPC_LDA, 4'h0, load A from RAM[operand]
OPC_ADD, 4'h1, A <= A + RAM[operand]
OPC_SUB, 4'h2, A <= A - RAM[operand]
OPC_OUT, 4'hE, output register <= A
OPC_HLT, 4'hF, stop sequencing

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  sequencing enable; 0 = hold state (single-step/pause)
opcode  in  4  IR[7:4], combinational from the instruction register
tstate  out  6  one-hot ring state, bit0 = T1
halted  out  1  sticky halt flag
pc_inc  out  1  program counter increment (Cp)
pc_en  out  1  PC drives bus (Ep)
mar_load  out  1  MAR loads from bus (Lm)
ram_en  out  1  RAM drives bus (CE)
ir_load  out  1  IR loads from bus (Li)
ir_en  out  1  IR lower nibble drives bus (Ei)
a_load  out  1  accumulator loads (La)
a_en  out  1  accumulator drives bus (Ea)
alu_sub  out  1  ALU subtract select (Su)
alu_en  out  1  ALU drives bus (Eu)
b_load  out  1  B register loads (Lb)
out_load  out  1  output register loads (Lo)

Behaviour:
- Registers: tstate and halted only. All strobes are combinational decode of (tstate, opcode), gated by: rst_n=1 AND run=1 AND halted=0. Otherwise every strobe = 0.
- Reset (async, rst_n=0): tstate=6'b000001, halted=0, all strobes 0. Reset mid-instruction aborts it; the next cycle after release is T1.
- Advance: on each rising edge with run=1 and halted=0, tstate rotates left (T6 -> T1). run=0 holds tstate and halted.
- Fetch, independent of opcode:
  - T1: pc_en, mar_load
  - T2: pc_inc
  - T3: ram_en, ir_load
- The opcode is valid from T4, because IR loads on the edge ending T3.
- Execute:
  - LDA: T4 ir_en+mar_load; T5 ram_en+a_load; T6 none
  - ADD: T4 ir_en+mar_load; T5 ram_en+b_load; T6 alu_en+a_load (alu_sub=0)
  - SUB: as ADD, but T6 asserts alu_sub+alu_en+a_load
  - OUT: T4 a_en+out_load; T5, T6 none
  - HLT: T4 no strobes; on the edge ending T4, halted<=1 and tstate<=6'b000000. The block then stays frozen with all strobes 0 until rst_n=0.
  - Any other opcode: NOP. T4..T6 assert no strobes; the ring continues to the next fetch.
- Invariant: at most one bus driver (pc_en, ram_en, ir_en, a_en, alu_en) is high in any cycle.
- alu_sub is 0 whenever alu_en is 0.
- Instruction latency is 6 cycles with run held at 1. HLT takes effect 4 cycles after T1 of the HLT fetch.
- An opcode change during T1..T3 has no effect on strobes.
- run deasserted mid-T4..T6 holds state. Strobes for that T-state reassert when run returns.

Test Plan:
- Reset, then release with run=1 and opcode=4'h0 for 6 cycles -> tstate sequence 01,02,04,08,10,20,01. Strobes: T1 pc_en+mar_load, T2 pc_inc, T3 ram_en+ir_load, T4 ir_en+mar_load, T5 ram_en+a_load, T6 none.
- opcode=4'h2 at T4..T6 -> T5 ram_en+b_load. T6 alu_sub=alu_en=a_load=1, with all other strobes 0.
- opcode=4'hE -> T4 a_en+out_load only. T5/T6 all 0. The next cycle is T1.
- opcode=4'hF -> after the T4 edge, halted=1 and tstate=0. All strobes stay 0 for 20 more cycles. rst_n pulse low -> tstate=01, halted=0.
- run=0 during T2 for 3 cycles -> tstate stays 02 and pc_inc=0. run=1 -> pc_inc=1 for exactly one cycle, then T3.
- Assert rst_n=0 asynchronously mid-T5 of an ADD -> tstate=01 immediately, without a clock edge, and all strobes 0. Then run the randomized-opcode check: bus drivers are one-hot-or-zero every cycle.
